// File: rtl/square_sequential_if.sv
// square_sequential_if: operand/result handshake bundle for the sequential squarer.
//
// Signals:
//   root      N/2 bits     operand, sampled on accept
//   rem       N/2+1 bits   remainder operand (only when SQUARE_REM_EN is defined)
//   in_valid  1            operand valid
//   in_ready  1            squarer idle, can accept an operand
//   res       N bits       result, stable while out_valid=1
//   ovf       1            result exceeded N bits
//   out_valid 1            result valid
//   out_ready 1            downstream accepts the result
//
// Modports: slave = squarer side, master = operand producer / result consumer.
// Build option: SQUARE_REM_EN adds the rem signal.
interface square_sequential_if #(
  parameter int N = 16
);
  logic [N/2-1:0] root;
`ifdef SQUARE_REM_EN
  logic [N/2:0]   rem;
`endif
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   res;
  logic           ovf;
  logic           out_valid;
  logic           out_ready;

  modport slave (
    input  root,
`ifdef SQUARE_REM_EN
    input  rem,
`endif
    input  in_valid,
    output in_ready,
    output res,
    output ovf,
    output out_valid,
    input  out_ready
  );

  modport master (
    output root,
`ifdef SQUARE_REM_EN
    output rem,
`endif
    output in_valid,
    input  in_ready,
    input  res,
    input  ovf,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/square_sequential.sv
// square_sequential: multi-cycle radix-2 shift-add squarer, one root bit per cycle.
// Rebuilds a radicand from a root (and optionally a remainder), so it can sit
// downstream of the sequential square-root unit for round-trip checking.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous, active-low reset
//   bus      square_sequential_if.slave (root/rem/in_valid/in_ready,
//            res/ovf/out_valid/out_ready)
//
// Build option: SQUARE_REM_EN
//   defined   - rem operand present, result = root*root + rem, ovf live
//   undefined - result = root*root, ovf tied to 0
// Latency (accept edge to out_valid) is N/2 edges in both builds.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready=1, waiting for an operand
// CALC  | one shift-add step per edge, N/2 edges in total
// DONE  | result held with out_valid=1 until out_ready
module square_sequential #(
  parameter int N = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  square_sequential_if.slave     bus
);
  localparam int RW = N / 2;
  localparam int CW = ($clog2(RW) < 1) ? 1 : $clog2(RW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N:0]      acc_q, acc_d;
  logic [N:0]      mcand_q, mcand_d;
  logic [RW-1:0]   mult_q, mult_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    res_q, res_d;
  logic [N:0]      acc_sum;
  logic [N:0]      acc_init;

`ifdef SQUARE_REM_EN
  logic            ovf_q, ovf_d;
  assign acc_init = {{RW{1'b0}}, bus.rem};
`else
  // Without a remainder the square always fits in N bits, so the carry
  // out of the accumulator is structurally dead.
  logic            unused_acc_msb;
  assign acc_init       = '0;
  assign unused_acc_msb = acc_sum[N];
`endif

  // Accumulator value after this cycle's conditional add; used both for the
  // running state and for the final result captured on the last step.
  assign acc_sum = mult_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mult_d      = mult_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
`ifdef SQUARE_REM_EN
    ovf_d       = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          mcand_d    = {{(RW+1){1'b0}}, bus.root};
          mult_d     = bus.root;
          acc_d      = acc_init;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end

      CALC: begin
        acc_d   = acc_sum;
        mcand_d = {mcand_q[N-1:0], 1'b0};
        mult_d  = mult_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(RW - 1)) begin
          res_d       = acc_sum[N-1:0];
`ifdef SQUARE_REM_EN
          ovf_d       = acc_sum[N];
`endif
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mult_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
`ifdef SQUARE_REM_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mult_q      <= mult_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
`ifdef SQUARE_REM_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
`ifdef SQUARE_REM_EN
  assign bus.ovf       = ovf_q;
`else
  assign bus.ovf       = 1'b0;
`endif
endmodule

// File: tb/tb_square_sequential.sv
// tb_square_sequential: directed self-checking bench for square_sequential (N=16).
// Inputs are driven and outputs sampled 1ns after the rising edge.
module tb_square_sequential;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  square_sequential_if #(.N(N)) bus ();

  square_sequential #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until out_valid is seen; lat = edges after the accepting edge.
  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.root      = '0;
`ifdef SQUARE_REM_EN
    bus.rem       = '0;
`endif
    step();
    step();
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests_run++; if (bus.res !== 16'h0000) begin tests_failed++; $display("FAIL reset_res: got %h want 0000", bus.res); end
    tests_run++; if (bus.ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    int lat;
    bus.out_ready = 1'b1;
    bus.root      = 8'hFF;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL lat_busy_in_ready: got %b want 0", bus.in_ready); end
    wait_out(lat);
    tests_run++; if (lat != 8) begin tests_failed++; $display("FAIL lat_edges: got %0d want 8", lat); end
    tests_run++; if (bus.res !== 16'hFE01) begin tests_failed++; $display("FAIL lat_res: got %h want fe01", bus.res); end
    tests_run++; if (bus.ovf !== 1'b0) begin tests_failed++; $display("FAIL lat_ovf: got %b want 0", bus.ovf); end
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL lat_done_in_ready: got %b want 0", bus.in_ready); end
    step();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_handoff_valid: got %b want 0", bus.out_valid); end
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL lat_handoff_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b1;
    bus.root      = 8'h00;
    bus.in_valid  = 1'b1;
    step();
    // Keep in_valid high with a new operand: it must wait for the handoff.
    bus.root = 8'h01;
    wait_out(lat);
    tests_run++; if (lat != 8) begin tests_failed++; $display("FAIL b2b_first_lat: got %0d want 8", lat); end
    tests_run++; if (bus.res !== 16'h0000) begin tests_failed++; $display("FAIL b2b_first_res: got %h want 0000", bus.res); end
    step();
    tests_run++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_handoff: got ready=%b valid=%b want ready=1 valid=0", bus.in_ready, bus.out_valid); end
    step();
    bus.in_valid = 1'b0;
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_second_accept: got ready=%b want 0", bus.in_ready); end
    wait_out(lat);
    tests_run++; if (lat != 8) begin tests_failed++; $display("FAIL b2b_second_lat: got %0d want 8", lat); end
    tests_run++; if (bus.res !== 16'h0001) begin tests_failed++; $display("FAIL b2b_second_res: got %h want 0001", bus.res); end
    step();
  endtask

  task automatic test_stall();
    int lat;
    bus.out_ready = 1'b0;
    bus.root      = 8'h80;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    wait_out(lat);
    tests_run++; if (lat != 8) begin tests_failed++; $display("FAIL stall_lat: got %0d want 8", lat); end
    for (int i = 0; i < 20; i++) begin
      step();
      tests_run++; if (bus.out_valid !== 1'b1 || bus.res !== 16'h4000) begin tests_failed++; $display("FAIL stall_hold cyc %0d: got valid=%b res=%h want valid=1 res=4000", i, bus.out_valid, bus.res); end
    end
    bus.out_ready = 1'b1;
    step();
    tests_run++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_release: got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.out_ready = 1'b1;
    bus.root      = 8'hAB;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    step();
    step();
    step();
    reset_n = 1'b0;
    step();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_ready: got %b want 1", bus.in_ready); end
    tests_run++; if (bus.res !== 16'h0000) begin tests_failed++; $display("FAIL mid_rst_res: got %h want 0000", bus.res); end
    reset_n      = 1'b1;
    bus.root     = 8'h0C;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_out(lat);
    tests_run++; if (lat != 8) begin tests_failed++; $display("FAIL mid_rst_next_lat: got %0d want 8", lat); end
    tests_run++; if (bus.res !== 16'h0090) begin tests_failed++; $display("FAIL mid_rst_next_res: got %h want 0090", bus.res); end
    step();
  endtask

`ifdef SQUARE_REM_EN
  task automatic test_rem();
    logic [7:0]  roots [4] = '{8'hFF, 8'hFF, 8'h0C, 8'h80};
    logic [8:0]  rems  [4] = '{9'h1FE, 9'h1FF, 9'h005, 9'h100};
    logic [15:0] exp_r [4] = '{16'hFFFF, 16'h0000, 16'h0095, 16'h4100};
    logic        exp_o [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.root     = roots[i];
      bus.rem      = rems[i];
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      wait_out(lat);
      tests_run++; if (lat != 8 || bus.res !== exp_r[i] || bus.ovf !== exp_o[i]) begin tests_failed++; $display("FAIL rem_vec %0d: got lat=%0d res=%h ovf=%b want lat=8 res=%h ovf=%b", i, lat, bus.res, bus.ovf, exp_r[i], exp_o[i]); end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef SQUARE_REM_EN
    test_rem();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
